proc_ctrl_fsm: RTL
==================

Name: proc_ctrl_fsm

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator processor. It owns the instruction register and drives the single shared memory port with a req/ack handshake. It issues one-cycle strobes to the datapath: PC increment/load and accumulator load with an ALU/memory source select. It also counts retired instructions and traps memory stalls into an error state.

Parameters:
MAX_WAIT, 15, maximum request cycles without mem_ack before trapping; legal range 1..255.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  enable; sampled only at instruction boundaries.
mem_ack  in  1  memory completes the current request this cycle.
mem_rdata  in  8  instruction on fetch, data on LOAD.
zero_flag  in  1  accumulator==0, supplied by the datapath.
mem_req  out  1  memory request, held until ack.
mem_we  out  1  write enable, STORE only.
addr_sel  out  1  address select: 0 = PC, 1 = operand.
pc_inc  out  1  PC+1 strobe.
pc_load  out  1  PC <= operand strobe.
acc_load  out  1  accumulator write strobe.
acc_src  out  1  accumulator source: 0 = ALU, 1 = mem_rdata.
alu_op  out  2  ALU operation: 00 PASS, 01 ADD, 10 SUB, 11 AND.
opcode_out  out  3  IR[7:5].
operand_out  out  5  IR[4:0].
busy  out  1  state is neither IDLE nor ERROR.
bus_error  out  1  sticky stall trap.
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Instruction format: {opcode[2:0], operand[4:0]}.
- Opcode encoding: NOP 000, LOAD 001, STORE 010, ADD 011, SUB 100, AND 101, JMP 110, JZ 111.
- Reset: state IDLE, IR 8'h00, instr_count 0, wait counter 0, bus_error 0. All outputs are 0 during and immediately after reset.
- Strobe gating: all strobes (pc_inc, pc_load, acc_load) and mem_req are gated by !rst, so there are no pulses in a reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, MEM, ERROR.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ack: IR <= mem_rdata and pc_inc=1 in the same cycle (Mealy); next state DECODE.
- DECODE (1 cycle):
  - NOP: retire; go to FETCH if run=1, else IDLE.
  - LOAD/STORE: go to MEM.
  - All other opcodes: go to EXEC.
- EXEC (1 cycle), then retire:
  - ADD/SUB/AND: acc_load=1, acc_src=0, alu_op=01/10/11; the ALU operand is the zero-extended operand_out.
  - JMP: pc_load=1.
  - JZ: pc_load=zero_flag.
- MEM: mem_req=1, addr_sel=1, mem_we=(opcode==STORE).
  - On mem_ack: if LOAD, acc_load=1, acc_src=1. Then retire.
- Retire: instr_count += 1; next state FETCH if run=1, else IDLE. run=0 mid-instruction never aborts the instruction.
- alu_op is 00 whenever acc_load is not an ALU write.
- Latency with zero-wait memory (ack in the first request cycle): every instruction takes exactly 3 cycles; NOP takes 2.
- Wait timer:
  - Clears on entry to FETCH/MEM and increments each request cycle without ack.
  - If ack is low in the MAX_WAIT-th request cycle, next state is ERROR.
  - Ack in that same MAX_WAIT-th cycle completes normally.
- ERROR: bus_error=1, mem_req=0, all strobes 0. mem_ack and run are ignored; only rst exits.
- mem_ack while mem_req=0 is ignored.
- rst and mem_ack in the same cycle: rst wins; no IR update, strobe, or count.

Decomposition:
- Package proc_ctrl_pkg: opcode localparams, state encoding, alu_op encoding.
- Sub-module proc_wait_timer: clear/enable/timeout counter parameterised by MAX_WAIT.
- Everything else stays in a single FSM module.

Test Plan:
- LOAD, zero-wait: rst, run=1, fetch rdata 8'b001_01010, MEM rdata 8'h3C -> states IDLE,FETCH,DECODE,MEM,FETCH. One pc_inc; operand_out=10. In the MEM ack cycle: addr_sel=1, acc_load=1, acc_src=1. instr_count=1.
- STORE 11 then ADD 2 -> STORE: mem_we=1 only in MEM, no acc_load. ADD: EXEC acc_load=1, acc_src=0, alu_op=01. instr_count=2 after 6 cycles.
- JZ 5 with zero_flag=0 -> no pc_load. JZ 5 with zero_flag=1 -> one pc_load pulse. JMP 0 -> pc_load regardless of zero_flag.
- MAX_WAIT=4, ack held low in FETCH -> 4 request cycles, then ERROR with bus_error=1 and mem_req=0. A later ack has no effect; rst returns to IDLE with bus_error=0. Repeat with ack in the 4th cycle -> no error.
- run dropped during DECODE of ADD -> EXEC completes and instr_count increments, then IDLE with busy=0 and mem_req=0.
- rst asserted together with mem_ack in MEM of a LOAD -> no acc_load pulse, instr_count=0, state IDLE on the next cycle.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the accumulator processor control sequencer:
// opcodes, FSM states, ALU operations and wait-timer sizing.
package proc_ctrl_pkg;

    // Instruction opcodes, IR[7:5]
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_JZ    = 3'b111;

    // ALU operation select driven towards the datapath
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    // Wide enough for the largest legal MAX_WAIT (255)
    localparam int WAIT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        code = ALU_PASS;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            default: code = ALU_PASS;
        endcase
        return code;
    endfunction

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/proc_wait_timer.sv
// Memory stall timer: counts request cycles without acknowledge and flags
// the cycle that is the MAX_WAIT-th consecutive request cycle.
module proc_wait_timer
    import proc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    localparam logic [WAIT_W-1:0] LAST_COUNT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] r_count;

    // Count holds the number of already-elapsed unacknowledged request cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {WAIT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == LAST_COUNT);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor:
// owns the IR, drives the shared memory port and issues datapath strobes.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_mem_ack,
    input  logic [7:0]       i_mem_rdata,
    input  logic             i_zero_flag,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_pc_inc,
    output logic             o_pc_load,
    output logic             o_acc_load,
    output logic             o_acc_src,
    output logic [1:0]       o_alu_op,
    output logic [2:0]       o_opcode_out,
    output logic [4:0]       o_operand_out,
    output logic             o_busy,
    output logic             o_bus_error,
    output logic [CNT_W-1:0] o_instr_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_ir;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_bus_error;

    logic       w_live;
    logic [2:0] w_opcode;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_addr_sel;
    logic       w_pc_inc;
    logic       w_pc_load;
    logic       w_acc_load;
    logic       w_acc_src;
    logic [1:0] w_alu_op;
    logic       w_ir_load;
    logic       w_retire;
    logic       w_timer_clear;
    logic       w_timer_en;
    logic       w_wait_last;

    assign w_live   = !i_rst;
    assign w_opcode = r_ir[7:5];

    proc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_last   (w_wait_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_ir          <= 8'h00;
            r_instr_count <= '0;
            r_bus_error   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_ir_load) begin
                r_ir <= i_mem_rdata;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            if (w_next_state == ST_ERROR) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_addr_sel   = 1'b0;
        w_pc_inc     = 1'b0;
        w_pc_load    = 1'b0;
        w_acc_load   = 1'b0;
        w_acc_src    = 1'b0;
        w_alu_op     = ALU_PASS;
        w_ir_load    = 1'b0;
        w_retire     = 1'b0;
        w_timer_en   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (i_mem_ack) begin
                    w_ir_load    = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_wait_last) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_timer_en = 1'b1;
                end
            end

            ST_DECODE: begin
                case (w_opcode)
                    OP_NOP:            w_retire     = 1'b1;
                    OP_LOAD, OP_STORE: w_next_state = ST_MEM;
                    default:           w_next_state = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                w_retire = 1'b1;
                if (is_alu_op(w_opcode)) begin
                    w_acc_load = 1'b1;
                    w_alu_op   = alu_code(w_opcode);
                end else if (w_opcode == OP_JMP) begin
                    w_pc_load = 1'b1;
                end else if (w_opcode == OP_JZ) begin
                    w_pc_load = i_zero_flag;
                end
            end

            ST_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (w_opcode == OP_STORE);
                if (i_mem_ack) begin
                    w_retire = 1'b1;
                    if (w_opcode == OP_LOAD) begin
                        w_acc_load = 1'b1;
                        w_acc_src  = 1'b1;
                    end
                end else if (w_wait_last) begin
                    w_next_state = ST_ERROR;
                end else begin
                    w_timer_en = 1'b1;
                end
            end

            ST_ERROR: begin
                w_next_state = ST_ERROR;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // run is only looked at once the current instruction has retired
        if (w_retire) begin
            w_next_state = i_run ? ST_FETCH : ST_IDLE;
        end
    end

    assign w_timer_clear = (w_next_state != r_state) &&
                           ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM));

    // Every output is forced low while reset is asserted
    assign o_mem_req     = w_live & w_mem_req;
    assign o_mem_we      = w_live & w_mem_we;
    assign o_addr_sel    = w_live & w_addr_sel;
    assign o_pc_inc      = w_live & w_pc_inc;
    assign o_pc_load     = w_live & w_pc_load;
    assign o_acc_load    = w_live & w_acc_load;
    assign o_acc_src     = w_live & w_acc_src;
    assign o_alu_op      = {2{w_live}} & w_alu_op;
    assign o_opcode_out  = {3{w_live}} & r_ir[7:5];
    assign o_operand_out = {5{w_live}} & r_ir[4:0];
    assign o_busy        = w_live & (r_state != ST_IDLE) & (r_state != ST_ERROR);
    assign o_bus_error   = w_live & r_bus_error;
    assign o_instr_count = {CNT_W{w_live}} & r_instr_count;

endmodule
